// File: rtl/iter_div_pkg.sv
// Shared constants, FSM state encoding and helpers for the iterative divider.
package iter_div_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_STEPS = 32;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivCalc = 2'd1,
        DivDone = 2'd2
    } div_state_e;

    // Magnitude of a two's-complement value; passes the value through when not signed.
    function automatic logic [DIV_W-1:0] abs_if(input logic [DIV_W-1:0] v, input logic en);
        return (en && v[DIV_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/iter_div_step.sv
// One combinational restoring-division iteration; the quotient bit is shifted into bit 0.
module div_step
    import iter_div_pkg::*;
(
    input  logic [2*DIV_W-1:0] i_rem,
    input  logic [DIV_W-1:0]   i_div,
    output logic [2*DIV_W-1:0] o_rem,
    output logic               o_qbit
);

    logic [DIV_W:0]   w_hi;
    logic [DIV_W-1:0] w_sub;

    // Upper 33 bits of the left-shifted partial remainder.
    assign w_hi   = i_rem[2*DIV_W-1:DIV_W-1];
    assign o_qbit = (w_hi >= {1'b0, i_div});
    // A successful subtract always leaves a value below the divisor, so 32 bits suffice.
    assign w_sub  = w_hi[DIV_W-1:0] - i_div;
    assign o_rem  = o_qbit ? {w_sub, i_rem[DIV_W-2:0], 1'b1}
                           : {i_rem[2*DIV_W-2:0], 1'b0};

endmodule

// File: rtl/iter_div.sv
// 32-bit multi-cycle restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// Define DIV_ZERO_SHORTCUT_EN to finish divide-by-zero without iterating.
module iter_div
    import iter_div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             div_valid,
    input  logic             div_signed,
    input  logic [DIV_W-1:0] x,
    input  logic [DIV_W-1:0] y,
    input  logic             cancel,
    output logic             div_ready,
    output logic             complete,
    output logic [DIV_W-1:0] s,
    output logic [DIV_W-1:0] r
);

    localparam logic [5:0] LastCnt = 6'(DIV_STEPS - 1);

    div_state_e         r_state;
    logic [5:0]         r_cnt;
    logic [2*DIV_W-1:0] r_rem;
    logic [DIV_W-1:0]   r_ydiv;
    logic [DIV_W-1:0]   r_x;
    logic               r_signed;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_y_zero;
    logic               r_complete;
    logic [DIV_W-1:0]   r_s;
    logic [DIV_W-1:0]   r_r;

    logic [2*DIV_W-1:0] w_step_rem;
    logic               w_qbit;
    logic               w_accept;
    logic               w_last;
    logic               w_skip;
    logic [DIV_W-1:0]   w_q_fin;
    logic [DIV_W-1:0]   w_rem_fin;
    logic [DIV_W-1:0]   w_s_fin;
    logic [DIV_W-1:0]   w_r_fin;

    div_step u_div_step (
        .i_rem  (r_rem),
        .i_div  (r_ydiv),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    assign div_ready = (r_state == DivIdle) | (r_state == DivDone);
    assign complete  = r_complete;
    assign s         = r_s;
    assign r         = r_r;

    assign w_accept  = div_valid & div_ready & ~cancel;
    assign w_last    = (r_cnt == LastCnt);
    assign w_q_fin   = w_step_rem[DIV_W-1:0];
    assign w_rem_fin = w_step_rem[2*DIV_W-1:DIV_W];

`ifdef DIV_ZERO_SHORTCUT_EN
    assign w_skip = r_y_zero;
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_s_fin = w_q_fin;
        w_r_fin = w_rem_fin;
        if (r_y_zero) begin
            w_s_fin = '1;
            w_r_fin = r_x;
        end else if (r_signed) begin
            w_s_fin = r_sign_q ? (~w_q_fin + 1'b1) : w_q_fin;
            w_r_fin = r_sign_r ? (~w_rem_fin + 1'b1) : w_rem_fin;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= DivIdle;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_ydiv     <= '0;
            r_x        <= '0;
            r_signed   <= 1'b0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_y_zero   <= 1'b0;
            r_complete <= 1'b0;
            r_s        <= '0;
            r_r        <= '0;
        end else begin
            r_complete <= 1'b0;
            if (cancel) begin
                r_state <= DivIdle;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    DivIdle, DivDone: begin
                        if (w_accept) begin
                            r_rem    <= {{DIV_W{1'b0}}, abs_if(x, div_signed)};
                            r_ydiv   <= abs_if(y, div_signed);
                            r_x      <= x;
                            r_signed <= div_signed;
                            r_sign_q <= x[DIV_W-1] ^ y[DIV_W-1];
                            r_sign_r <= x[DIV_W-1];
                            r_y_zero <= (y == '0);
                            r_cnt    <= '0;
                            r_state  <= DivCalc;
                        end else begin
                            r_state <= DivIdle;
                        end
                    end
                    DivCalc: begin
                        // The last step's result goes straight into correction, not r_rem.
                        if (w_skip || w_last) begin
                            r_state    <= DivDone;
                            r_complete <= 1'b1;
                            r_s        <= w_s_fin;
                            r_r        <= w_r_fin;
                            r_cnt      <= '0;
                        end else begin
                            r_rem <= w_step_rem;
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    default: r_state <= DivIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Scoreboard bench for iter_div: expected results are queued at accept and matched on complete.
module tb_iter_div;

    logic        clk;
    logic        reset;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        cancel;
    logic        div_ready;
    logic        complete;
    logic [31:0] s;
    logic [31:0] r;

    iter_div dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .cancel     (cancel),
        .div_ready  (div_ready),
        .complete   (complete),
        .s          (s),
        .r          (r)
    );

    typedef struct {
        string       tag;
        logic [31:0] es;
        logic [31:0] er;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_s = '0;
    logic [31:0] last_r = '0;
    logic        mon_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void model(input logic [31:0] xi, input logic [31:0] yi, input logic sg,
                                  output logic [31:0] es, output logic [31:0] er);
        if (yi == 0) begin
            es = '1;
            er = xi;
        end else if (sg) begin
            if (xi == 32'h8000_0000 && yi == 32'hFFFF_FFFF) begin
                es = xi;
                er = '0;
            end else begin
                es = $signed(xi) / $signed(yi);
                er = $signed(xi) % $signed(yi);
            end
        end else begin
            es = xi / yi;
            er = xi % yi;
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for a single cycle; returns with cyc = accept cycle + 1.
    task automatic issue(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                         input logic sg, input logic push, input logic [31:0] es,
                         input logic [31:0] er);
        exp_t e;
        int   lat;
        lat = 33;
`ifdef DIV_ZERO_SHORTCUT_EN
        if (yi == 0) lat = 2;
`endif
        div_valid  = 1'b1;
        div_signed = sg;
        x          = xi;
        y          = yi;
        if (push) begin
            e.tag = tag;
            e.es  = es;
            e.er  = er;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        next_cycle();
        div_valid = 1'b0;
        x         = $urandom;
        y         = $urandom;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            next_cycle();
            k++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_exp = (sb.size() != 0) && (sb[0].cyc == cyc);
            if (mon_exp || complete) begin
                check("complete", {31'b0, complete}, {31'b0, mon_exp});
                if (mon_exp) begin
                    if (complete) begin
                        check({sb[0].tag, "_s"}, s, sb[0].es);
                        check({sb[0].tag, "_r"}, r, sb[0].er);
                        last_s = sb[0].es;
                        last_r = sb[0].er;
                    end
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] rx, ry, es, er;
        logic        rs;
        reset      = 1'b1;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        x          = '0;
        y          = '0;
        cancel     = 1'b0;
        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, div_ready}, 32'd1);
        check("rst_complete", {31'b0, complete}, 32'd0);
        check("rst_s", s, 32'd0);
        check("rst_r", r, 32'd0);
        next_cycle();

        // Unsigned 100/7 with busy window checked every CALC cycle.
        issue("u100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("busy", {31'b0, div_ready}, 32'd0);
            next_cycle();
        end
        drain();

        issue("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        drain();
        issue("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'd0);
        drain();
        issue("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 32'h8000_0000);
        drain();
        issue("s_div0", 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        drain();
        issue("u_div0", 32'd12345, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd12345);
        drain();

        // Cancel in the 10th CALC cycle: nothing completes, outputs keep old values.
        issue("cancel", 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (9) next_cycle();
        cancel = 1'b1;
        next_cycle();
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_ready", {31'b0, div_ready}, 32'd1);
        check("cancel_s", s, last_s);
        check("cancel_r", r, last_r);
        next_cycle();
        issue("u9_3", 32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0);
        drain();

        // Cancel beats a same-cycle accept.
        cancel = 1'b1;
        issue("cancel_acc", 32'd50, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0);
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_acc_ready", {31'b0, div_ready}, 32'd1);
        next_cycle();

        // Back-to-back: second request accepted in the DONE cycle of the first.
        issue("u50_5", 32'd50, 32'd5, 1'b0, 1'b1, 32'd10, 32'd0);
        repeat (32) next_cycle();
        issue("u20_6", 32'd20, 32'd6, 1'b0, 1'b1, 32'd3, 32'd2);
        drain();

        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = (i == 3) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
            rs = 1'($urandom_range(0, 1));
            model(rx, ry, rs, es, er);
            issue("rand", rx, ry, rs, 1'b1, es, er);
            drain();
        end

        // Reset mid-CALC discards the operation and clears the results.
        issue("reset_mid", 32'd1000, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_complete", {31'b0, complete}, 32'd0);
        check("rstmid_s", s, 32'd0);
        check("rstmid_r", r, 32'd0);
        check("rstmid_ready", {31'b0, div_ready}, 32'd1);
        repeat (40) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
